// File: rtl/bufn_fifo.sv
// bufn_fifo: parametrised first-word-fall-through FIFO with valid/ready on
// both sides. Registered successor of the fixed 4-bit TURBO_IO pass-through
// buffer; sits between the IO adapter and the DLX core.
//
// Optional feature macro: BUFN_PARITY_EN
//   defined   -> each entry carries an even-parity bit (with err_inj to
//                corrupt it on push); a parity mismatch seen on a pop sets
//                the sticky parity_err flag until reset.
//   undefined -> plain WIDTH-bit storage, no err_inj port, parity_err = 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready and out_valid depend only on registered
// occupancy, never combinationally on the opposite side's valid/ready, so a
// full FIFO refuses a push even in a cycle where it is being popped.
module bufn_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
`ifdef BUFN_PARITY_EN
  input  logic                       err_inj,
`endif
  output logic                       parity_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef BUFN_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;

  // Handshake qualifiers derived from registered occupancy only.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
    count     = count_q;
  end

  // Build the entry written on a push (data plus optional parity bit).
  always_comb begin
`ifdef BUFN_PARITY_EN
    wr_entry = {(^in_data) ^ err_inj, in_data};
`else
    wr_entry = in_data;
`endif
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset clears storage so out_data reads 0 when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef BUFN_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Sticky error: set when the word being popped disagrees with its parity.
  always_comb begin
    parity_err_d = parity_err_q;
    if (pop && (mem_q[rd_ptr_q][WIDTH] != (^mem_q[rd_ptr_q][WIDTH-1:0]))) begin
      parity_err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bufn_fifo.sv
// Testbench for bufn_fifo (WIDTH=4, DEPTH=4). A table of per-cycle vectors
// with hand-computed occupancy drives the FIFO; a reference queue holds the
// words expected at the head. Reset-in-flight and parity (BUFN_PARITY_EN)
// cases are written out by hand.
module tb_bufn_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             err_inj = 1'b0;
  logic             parity_err;

  logic [WIDTH-1:0] exp_q[$];
  logic             inj_q[$];
  int               mc = 0;
  logic             pe_exp = 1'b0;
  int               checks = 0;
  int               errors = 0;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;
    int               cnt_after;
  } vec_t;

  vec_t vecs[$];

  bufn_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
`ifdef BUFN_PARITY_EN
    .err_inj    (err_inj),
`endif
    .parity_err (parity_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic inj);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    err_inj   = inj;
    #1;
    check("in_ready", in_ready, (mc != DEPTH));
    check("out_valid", out_valid, (mc != 0));
    if (mc != 0) check("out_data", out_data, exp_q[0]);
    check("parity_err", parity_err, pe_exp);
    do_push = v && (mc != DEPTH);
    do_pop  = r && (mc != 0);
    @(posedge clk);
    if (do_pop) begin
      void'(exp_q.pop_front());
      if (inj_q.pop_front()) pe_exp = 1'b1;
    end
    if (do_push) begin
      exp_q.push_back(d);
      inj_q.push_back(inj);
    end
    mc = mc + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_inj = 1'b0;
    check("count", count, mc);
  endtask

  task automatic add(input logic v, input logic [WIDTH-1:0] d, input logic r, input int c);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.cnt_after = c;
    vecs.push_back(x);
  endtask

  task automatic model_reset();
    exp_q.delete();
    inj_q.delete();
    mc = 0;
    pe_exp = 1'b0;
  endtask

  initial begin
    // Vector table: {in_valid, in_data, out_ready, count after edge}
    // push 1,2,3 with consumer stalled
    add(1, 4'h1, 0, 1); add(1, 4'h2, 0, 2); add(1, 4'h3, 0, 3);
    // drain
    add(0, 4'h0, 1, 2); add(0, 4'h0, 1, 1); add(0, 4'h0, 1, 0);
    // fill A..D, then E while full is dropped
    add(1, 4'hA, 0, 1); add(1, 4'hB, 0, 2); add(1, 4'hC, 0, 3); add(1, 4'hD, 0, 4);
    add(1, 4'hE, 0, 4);
    add(0, 4'h0, 1, 3); add(0, 4'h0, 1, 2); add(0, 4'h0, 1, 1); add(0, 4'h0, 1, 0);
    add(0, 4'h0, 0, 0);
    // streaming 0..9 through an initially empty FIFO
    add(1, 4'h0, 1, 1);
    for (int i = 1; i < 10; i++) add(1, 4'(i), 1, 1);
    add(0, 4'h0, 1, 0);
    // simultaneous push/pop at count 2
    add(1, 4'h5, 0, 1); add(1, 4'h6, 0, 2); add(1, 4'h7, 1, 2);
    add(0, 4'h0, 1, 1); add(0, 4'h0, 1, 0);
    // full + pop in same cycle: push refused, pop taken
    add(1, 4'h1, 0, 1); add(1, 4'h2, 0, 2); add(1, 4'h3, 0, 3); add(1, 4'h4, 0, 4);
    add(1, 4'h9, 1, 3);
    add(0, 4'h0, 1, 2); add(0, 4'h0, 1, 1); add(0, 4'h0, 1, 0);
    // random traffic
    for (int i = 0; i < 40; i++) add(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);

    // Reset
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_parity_err", parity_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, 1'b0);
      if (vecs[i].cnt_after >= 0) check($sformatf("vec%0d_count", i), count, vecs[i].cnt_after);
    end
    while (mc != 0) step(1'b0, '0, 1'b1, 1'b0);

    // Reset asserted mid-cycle with three words held
    step(1, 4'h1, 0, 0); step(1, 4'h2, 0, 0); step(1, 4'h3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_count", count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'h5, 0, 0);
    #1;
    check("postrst_out_data", out_data, 4'h5);
    check("postrst_count", count, 1);
    @(negedge clk);
    step(0, 4'h0, 1, 0);

`ifdef BUFN_PARITY_EN
    // Corrupted parity on push is flagged after the pop and stays sticky
    step(1, 4'h3, 0, 1);
    check("par_before_pop", parity_err, 0);
    step(0, 4'h0, 1, 0);
    check("par_after_pop", parity_err, 1);
    step(1, 4'h6, 1, 0);
    step(0, 4'h0, 1, 0);
    check("par_sticky", parity_err, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("par_cleared", parity_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'h9, 0, 0);
    step(0, 4'h0, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bufn_fifo.md
# bufn_fifo

Parametrised, registered successor to the fixed 4-bit pass-through buffer in the TURBO_IO path. It stores up to DEPTH words of WIDTH bits in a first-word-fall-through FIFO with valid/ready handshakes on both sides. This decouples a producer from a stalling consumer between the IO adapter and the DLX core. An optional parity layer detects storage corruption for the SafeDLX fault-detection flow.

## Interface
- WIDTH, 4, data word width in bits (≥1).
- DEPTH, 4, number of storage entries (power of 2, ≥2).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  write data.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  FIFO accepts a word this cycle.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_inj  input  1  present only with BUFN_PARITY_EN; flips stored parity on push.
- parity_err  output  1  sticky parity-error flag (tied 0 without BUFN_PARITY_EN).

## Operation
- Push when in_valid && in_ready. The word is written to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Pop when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. A full FIFO refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr], read combinationally from registered storage (FWFT).
- count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged, with both pointers advancing.
  - Neither: unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- in_data is ignored when in_valid=0 or in_ready=0. A push attempted while full is dropped with no state change.
- Data order is strictly preserved. No word is duplicated or lost across pointer wrap-around.

## Timing
- Reset (asynchronous assert, synchronous release):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage cleared to 0.
  - out_valid=0, out_data=0, in_ready=1, parity_err=0.
- Reset asserted mid-transfer discards all contents immediately. The first push after release lands at entry 0.
- Write-to-read latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained when neither side stalls and 0<count<DEPTH.
- From full, in_ready rises the cycle after the first pop.

## Configuration
- BUFN_PARITY_EN defined:
  - Each entry stores WIDTH+1 bits, the extra bit being even parity (^in_data XOR err_inj) captured at push.
  - On every pop, the stored parity is compared against ^out_data. A mismatch sets parity_err on the following edge.
  - parity_err stays set until rst_n is asserted. Data still pops normally; no data correction.
- BUFN_PARITY_EN undefined:
  - Storage is WIDTH bits and the err_inj port does not exist.
  - parity_err is constant 0.
  - Behaviour is otherwise identical.

## Test plan
- Reset, then push 0x1,0x2,0x3 with out_ready=0 → count=3, out_data=0x1, out_valid=1, in_ready=1.
- Fill DEPTH=4 with 0xA,0xB,0xC,0xD, then assert in_valid with 0xE while full → in_ready=0, 0xE dropped, count=4. Pops then return A,B,C,D and out_valid=0.
- Continuous push/pop for 10 words 0x0..0x9 starting empty (wrap twice) → out sequence 0..9 in order, count never exceeds 1, one word/cycle after 1-cycle latency.
- At count=2, assert push 0x7 and pop together → count stays 2 and the popped word is the oldest. 0x7 appears after the remaining word.
- Push 3 words, assert rst_n=0 mid-cycle → outputs reach reset values immediately. After release, push 0x5 gives out_data=0x5 at count=1.
- (BUFN_PARITY_EN) Push 0x3 with err_inj=1, then pop → parity_err=1 after the pop edge and remains 1 through further clean pushes/pops until reset.
